// File: rtl/reg_timer_if.sv
// Register-bank bus for reg_timer: config vector in, status vector and
// level interrupt out, plus the enable and the optional capture strobe.
interface reg_timer_if #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8
);
  logic                            ena;
  logic [NUM_CFG*REG_WIDTH-1:0]    rw_regs;
  logic [NUM_STATUS*REG_WIDTH-1:0] ro_regs;
  logic                            capture_i;
  logic                            irq;

  modport master (
    output ena, rw_regs, capture_i,
    input  ro_regs, irq
  );

  modport slave (
    input  ena, rw_regs, capture_i,
    output ro_regs, irq
  );
endinterface

// File: rtl/reg_timer.sv
// reg_timer: register-mapped 16-bit prescaled timer / comparator.
// CFG0 CTRL {IRQ_EN,CLR,ONESHOT,EN}, CFG1 PRESCALE, CFG2/3 CMP.
// ST0/1 CNT, ST2 FLAGS {CAP,DONE,RUNNING,MATCH}, ST3 MATCH_CNT, ST4/5 CAP.
// Optional feature macro: REG_TIMER_CAPTURE_EN enables the synchronised
// capture_i input; without it ST4, ST5 and FLAGS[3] read 0.
module reg_timer #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8
) (
  input  logic       clk,
  input  logic       rstb,
  reg_timer_if.slave bus
);

  localparam int CW = 2 * REG_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturating increment for the match counter.
  function automatic logic [REG_WIDTH-1:0] sat_inc(input logic [REG_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Config decode (sampled live, no shadowing)
  logic [REG_WIDTH-1:0] cfg_ctrl;
  logic [REG_WIDTH-1:0] cfg_prescale;
  logic [CW-1:0]        cfg_cmp;
  logic                 cfg_en;
  logic                 cfg_oneshot;
  logic                 cfg_clr;
  logic                 cfg_irq_en;

  assign cfg_ctrl     = bus.rw_regs[0 +: REG_WIDTH];
  assign cfg_prescale = bus.rw_regs[REG_WIDTH +: REG_WIDTH];
  assign cfg_cmp      = {bus.rw_regs[3*REG_WIDTH +: REG_WIDTH],
                         bus.rw_regs[2*REG_WIDTH +: REG_WIDTH]};
  assign cfg_en       = cfg_ctrl[0];
  assign cfg_oneshot  = cfg_ctrl[1];
  assign cfg_clr      = cfg_ctrl[2];
  assign cfg_irq_en   = cfg_ctrl[3];

  // Upper CTRL bits and CFG4+ are don't-care.
  logic unused_rw;
  assign unused_rw = ^bus.rw_regs;

  // Timer state
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [REG_WIDTH-1:0] presc;
  logic                 match_flag;
  logic [REG_WIDTH-1:0] match_cnt;
  logic                 clr_d;
  logic                 irq_r;
  logic                 cap_flag;
  logic [CW-1:0]        cap_val;

  logic                 clr_pulse;
  logic                 run_active;
  logic                 tick;
  logic                 hit;
  logic [CW-1:0]        cnt_nxt;
  logic                 match_nxt;

  assign clr_pulse  = cfg_clr & ~clr_d;
  assign run_active = (state == RUN) && cfg_en;
  assign tick       = run_active && (presc == cfg_prescale);
  assign hit        = (cnt == cfg_cmp);

  // Next counter / sticky match values; clear beats tick and match.
  always_comb begin
    cnt_nxt   = cnt;
    match_nxt = match_flag;
    if (clr_pulse) begin
      cnt_nxt   = '0;
      match_nxt = 1'b0;
    end else if (tick) begin
      if (hit) begin
        cnt_nxt   = cfg_oneshot ? cnt : '0;
        match_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // FSM, prescaler, counter, match bookkeeping and registered irq.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      cnt        <= '0;
      presc      <= '0;
      match_flag <= 1'b0;
      match_cnt  <= '0;
      clr_d      <= 1'b0;
      irq_r      <= 1'b0;
    end else if (bus.ena) begin
      clr_d      <= cfg_clr;
      cnt        <= cnt_nxt;
      match_flag <= match_nxt;
      irq_r      <= match_nxt & cfg_irq_en;

      if (clr_pulse) begin
        presc     <= '0;
        match_cnt <= '0;
      end else if (tick) begin
        presc <= '0;
        if (hit) match_cnt <= sat_inc(match_cnt);
      end else if (run_active) begin
        presc <= presc + 1'b1;
      end

      case (state)
        IDLE: if (cfg_en) state <= RUN;
        RUN: begin
          if (!cfg_en)                                         state <= IDLE;
          else if (tick && hit && cfg_oneshot && !clr_pulse)   state <= DONE;
        end
        DONE: if (!cfg_en || clr_pulse) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_TIMER_CAPTURE_EN
  logic cap_s1;
  logic cap_s2;
  logic cap_s3;
  logic cap_rise;

  assign cap_rise = cap_s2 & ~cap_s3;

  // Two-flop synchroniser, edge detect and capture register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cap_s1   <= 1'b0;
      cap_s2   <= 1'b0;
      cap_s3   <= 1'b0;
      cap_flag <= 1'b0;
      cap_val  <= '0;
    end else if (bus.ena) begin
      cap_s1 <= bus.capture_i;
      cap_s2 <= cap_s1;
      cap_s3 <= cap_s2;
      if (clr_pulse) begin
        cap_flag <= 1'b0;
      end else if (cap_rise) begin
        cap_val  <= cnt_nxt;
        cap_flag <= 1'b1;
      end
    end
  end
`else
  logic unused_cap;
  assign unused_cap = bus.capture_i;
  assign cap_flag   = 1'b0;
  assign cap_val    = '0;
`endif

  // Status vector: straight wiring of the state flops.
  always_comb begin
    logic [REG_WIDTH-1:0] flags;
    flags    = '0;
    flags[0] = match_flag;
    flags[1] = (state == RUN);
    flags[2] = (state == DONE);
    flags[3] = cap_flag;
    bus.ro_regs                          = '0;
    bus.ro_regs[0 +: REG_WIDTH]           = cnt[REG_WIDTH-1:0];
    bus.ro_regs[REG_WIDTH +: REG_WIDTH]   = cnt[CW-1:REG_WIDTH];
    bus.ro_regs[2*REG_WIDTH +: REG_WIDTH] = flags;
    bus.ro_regs[3*REG_WIDTH +: REG_WIDTH] = match_cnt;
    bus.ro_regs[4*REG_WIDTH +: REG_WIDTH] = cap_val[REG_WIDTH-1:0];
    bus.ro_regs[5*REG_WIDTH +: REG_WIDTH] = cap_val[CW-1:REG_WIDTH];
  end

  assign bus.irq = irq_r;

endmodule
